mux_n_pipe: RTL and testbench

- Parametrised N-way datapath selector with a registered output stage and valid/ready flow control.
- Successor to the fixed 8-input, 64-bit combinational selectors in the datapath (memory / ALU / constant / PC write-back and operand selection).
- A 2-entry skid buffer lets the selector sit between pipeline stages without a combinational ready path.
- Out-of-range selects are detected, substituted with a default word, and flagged.

---
 rtl/mux_n_pipe.sv | 119 +++++++++++
 tb/tb_mux_n_pipe.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_pipe.sv
// N-way word selector with a registered output stage and a 2-entry skid buffer.
// Out-of-range selects deliver DEFAULT_VAL and raise the sticky sel_err flag.
module mux_n_pipe #(
    parameter int               WIDTH       = 64,
    parameter int               N_IN        = 8,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
    localparam int              SEL_W       = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  err_clr,
    output logic                  sel_err
);

    localparam logic [SEL_W:0] N_IN_EXT = (SEL_W + 1)'(N_IN);

    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [SEL_W-1:0] main_sel_q, main_sel_d;
    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             sel_err_q, sel_err_d;

    logic [WIDTH-1:0] cap_data;
    logic             sel_oor;
    logic             accept;
    logic             pop;

    // Unmatched select codes fall through to DEFAULT_VAL.
    always_comb begin
        cap_data = DEFAULT_VAL;
        for (int k = 0; k < N_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                cap_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_oor = ({1'b0, sel} >= N_IN_EXT);
    assign accept  = in_valid && in_ready_q;
    assign pop     = main_valid_q && out_ready;

    always_comb begin
        main_data_d  = main_data_q;
        main_sel_d   = main_sel_q;
        main_valid_d = main_valid_q;
        skid_data_d  = skid_data_q;
        skid_sel_d   = skid_sel_q;
        skid_valid_d = skid_valid_q;
        sel_err_d    = sel_err_q;

        if (!main_valid_q || pop) begin
            // Skid full implies in_ready was low, so no accept can collide here.
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                main_sel_d   = skid_sel_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_data_d  = cap_data;
                main_sel_d   = sel;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_data_d  = cap_data;
            skid_sel_d   = sel;
            skid_valid_d = 1'b1;
        end

        if (accept && sel_oor) begin
            sel_err_d = 1'b1;
        end else if (err_clr) begin
            sel_err_d = 1'b0;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_data_q  <= '0;
            main_sel_q   <= '0;
            main_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_sel_q   <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            sel_err_q    <= 1'b0;
        end else begin
            main_data_q  <= main_data_d;
            main_sel_q   <= main_sel_d;
            main_valid_q <= main_valid_d;
            skid_data_q  <= skid_data_d;
            skid_sel_q   <= skid_sel_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = main_data_q;
    assign out_sel   = main_sel_q;
    assign out_valid = main_valid_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: three configurations (8x64, 5x64 with default word, 3x32)
// checked against a 2-deep FIFO scoreboard model.
module tb_mux_n_pipe;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Instance 8x64
    logic [511:0] d8_in_data = '0;
    logic [2:0]   d8_sel = '0;
    logic         d8_in_valid = 1'b0;
    logic         d8_in_ready;
    logic [63:0]  d8_out_data;
    logic [2:0]   d8_out_sel;
    logic         d8_out_valid;
    logic         d8_out_ready = 1'b1;
    logic         d8_err_clr = 1'b0;
    logic         d8_sel_err;

    // Instance 5x64 with DEAD_BEEF default
    logic [319:0] d5_in_data = '0;
    logic [2:0]   d5_sel = '0;
    logic         d5_in_valid = 1'b0;
    logic         d5_in_ready;
    logic [63:0]  d5_out_data;
    logic [2:0]   d5_out_sel;
    logic         d5_out_valid;
    logic         d5_out_ready = 1'b1;
    logic         d5_err_clr = 1'b0;
    logic         d5_sel_err;

    // Instance 3x32
    logic [95:0]  d3_in_data = '0;
    logic [1:0]   d3_sel = '0;
    logic         d3_in_valid = 1'b0;
    logic         d3_in_ready;
    logic [31:0]  d3_out_data;
    logic [1:0]   d3_out_sel;
    logic         d3_out_valid;
    logic         d3_out_ready = 1'b1;
    logic         d3_err_clr = 1'b0;
    logic         d3_sel_err;

    mux_n_pipe #(.WIDTH(64), .N_IN(8)) u_dut8 (
        .clk(clk), .reset(reset), .in_data(d8_in_data), .sel(d8_sel),
        .in_valid(d8_in_valid), .in_ready(d8_in_ready), .out_data(d8_out_data),
        .out_sel(d8_out_sel), .out_valid(d8_out_valid), .out_ready(d8_out_ready),
        .err_clr(d8_err_clr), .sel_err(d8_sel_err)
    );

    mux_n_pipe #(.WIDTH(64), .N_IN(5), .DEFAULT_VAL(64'hDEAD_BEEF)) u_dut5 (
        .clk(clk), .reset(reset), .in_data(d5_in_data), .sel(d5_sel),
        .in_valid(d5_in_valid), .in_ready(d5_in_ready), .out_data(d5_out_data),
        .out_sel(d5_out_sel), .out_valid(d5_out_valid), .out_ready(d5_out_ready),
        .err_clr(d5_err_clr), .sel_err(d5_sel_err)
    );

    mux_n_pipe #(.WIDTH(32), .N_IN(3)) u_dut3 (
        .clk(clk), .reset(reset), .in_data(d3_in_data), .sel(d3_sel),
        .in_valid(d3_in_valid), .in_ready(d3_in_ready), .out_data(d3_out_data),
        .out_sel(d3_out_sel), .out_valid(d3_out_valid), .out_ready(d3_out_ready),
        .err_clr(d3_err_clr), .sel_err(d3_sel_err)
    );

    // Scoreboard for the 8x64 instance
    logic [63:0] q8d[$];
    logic [2:0]  q8s[$];
    logic [63:0] last8 = '0;

    function automatic logic [63:0] word8(input logic [2:0] s);
        return d8_in_data[int'(s)*64 +: 64];
    endfunction

    function automatic logic [63:0] basic_word(input int k);
        return 64'h1111_0000_0000_0000 * 64'(k + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle on the 8x64 instance, updating the FIFO model.
    task automatic step8();
        logic acc;
        logic pp;
        logic [2:0] dummy;
        acc = d8_in_valid && (q8d.size() < 2);
        pp  = d8_out_ready && (q8d.size() > 0);
        if (pp) begin
            last8 = q8d.pop_front();
            dummy = q8s.pop_front();
        end
        if (acc) begin
            q8d.push_back(word8(d8_sel));
            q8s.push_back(d8_sel);
        end
        tick();
    endtask

    task automatic load_basic8();
        for (int k = 0; k < 8; k++) d8_in_data[k*64 +: 64] = basic_word(k);
    endtask

    task automatic test_reset();
        total++;
        if (d8_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", d8_out_valid); end
        total++;
        if (d8_out_data !== 64'h0) begin bad++; $display("[TB] FAIL reset_out_data: got %h want 0", d8_out_data); end
        total++;
        if (d8_out_sel !== 3'd0) begin bad++; $display("[TB] FAIL reset_out_sel: got %h want 0", d8_out_sel); end
        total++;
        if (d8_in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", d8_in_ready); end
        total++;
        if (d5_sel_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_sel_err: got %b want 0", d5_sel_err); end
    endtask

    task automatic test_basic_select();
        logic [63:0] exp;
        load_basic8();
        d8_out_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                exp = basic_word(i - 1);
                total++;
                if (d8_out_valid !== 1'b1) begin bad++; $display("[TB] FAIL basic_valid[%0d]: got %b want 1", i-1, d8_out_valid); end
                total++;
                if (d8_out_data !== exp) begin bad++; $display("[TB] FAIL basic_data[%0d]: got %h want %h", i-1, d8_out_data, exp); end
                total++;
                if (d8_out_sel !== 3'(i - 1)) begin bad++; $display("[TB] FAIL basic_sel[%0d]: got %0d want %0d", i-1, d8_out_sel, i-1); end
            end
            total++;
            if (d8_in_ready !== 1'b1) begin bad++; $display("[TB] FAIL basic_in_ready[%0d]: got %b want 1", i, d8_in_ready); end
            d8_in_valid = (i < 8);
            d8_sel = 3'(i);
            step8();
        end
        total++;
        if (d8_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_drain: got %b want 0", d8_out_valid); end
        total++;
        if (d8_sel_err !== 1'b0) begin bad++; $display("[TB] FAIL pow2_sel_err: got %b want 0", d8_sel_err); end
    endtask

    task automatic test_idle();
        logic [63:0] held;
        held = last8;
        d8_in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d8_in_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            d8_sel = 3'($urandom_range(0, 7));
            step8();
            total++;
            if (d8_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL idle_valid[%0d]: got %b want 0", i, d8_out_valid); end
            total++;
            if (d8_out_data !== held) begin bad++; $display("[TB] FAIL idle_hold[%0d]: got %h want %h", i, d8_out_data, held); end
        end
    endtask

    task automatic test_backpressure();
        load_basic8();
        d8_out_ready = 1'b0;
        d8_in_valid = 1'b1;
        d8_sel = 3'd1;
        step8();
        d8_sel = 3'd2;
        step8();
        total++;
        if (d8_in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready_low: got %b want 0", d8_in_ready); end
        total++;
        if (d8_out_data !== basic_word(1)) begin bad++; $display("[TB] FAIL bp_hold_a: got %h want %h", d8_out_data, basic_word(1)); end
        d8_sel = 3'd3;
        step8();
        total++;
        if (d8_out_data !== basic_word(1) || d8_out_sel !== 3'd1) begin
            bad++; $display("[TB] FAIL bp_stall_stable: got %h/%0d want %h/1", d8_out_data, d8_out_sel, basic_word(1));
        end
        d8_in_valid = 1'b0;
        d8_out_ready = 1'b1;
        step8();
        total++;
        if (d8_out_data !== basic_word(2) || d8_out_sel !== 3'd2 || d8_out_valid !== 1'b1) begin
            bad++; $display("[TB] FAIL bp_b_order: got %h/%0d v=%b want %h/2 v=1", d8_out_data, d8_out_sel, d8_out_valid, basic_word(2));
        end
        total++;
        if (d8_in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_in_ready_back: got %b want 1", d8_in_ready); end
        step8();
        total++;
        if (d8_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_empty: got %b want 0", d8_out_valid); end
    endtask

    task automatic test_no_accept();
        d8_out_ready = 1'b0;
        d8_in_valid = 1'b1;
        d8_sel = 3'd0;
        step8();
        d8_sel = 3'd1;
        step8();
        d8_sel = 3'd5;
        step8();
        d8_out_ready = 1'b1;
        step8();
        total++;
        if (d8_out_data !== basic_word(1)) begin bad++; $display("[TB] FAIL na_second: got %h want %h", d8_out_data, basic_word(1)); end
        d8_sel = 3'd6;
        step8();
        total++;
        if (d8_out_data !== basic_word(6) || d8_out_sel !== 3'd6) begin
            bad++; $display("[TB] FAIL na_later_word: got %h/%0d want %h/6", d8_out_data, d8_out_sel, basic_word(6));
        end
        d8_in_valid = 1'b0;
        step8();
        total++;
        if (d8_out_valid !== 1'b0 || q8d.size() != 0) begin bad++; $display("[TB] FAIL na_drain: got v=%b want 0", d8_out_valid); end
    endtask

    task automatic test_out_of_range();
        for (int k = 0; k < 5; k++) d5_in_data[k*64 +: 64] = 64'hA5A5_0000_0000_0000 + 64'(k);
        d5_out_ready = 1'b1;
        d5_in_valid = 1'b1;
        d5_sel = 3'd6;
        tick();
        total++;
        if (d5_out_data !== 64'hDEAD_BEEF || d5_out_sel !== 3'd6 || d5_out_valid !== 1'b1) begin
            bad++; $display("[TB] FAIL oor_default: got %h/%0d v=%b want deadbeef/6 v=1", d5_out_data, d5_out_sel, d5_out_valid);
        end
        total++;
        if (d5_sel_err !== 1'b1) begin bad++; $display("[TB] FAIL oor_err_set: got %b want 1", d5_sel_err); end
        d5_in_valid = 1'b0;
        tick();
        tick();
        total++;
        if (d5_sel_err !== 1'b1) begin bad++; $display("[TB] FAIL oor_sticky: got %b want 1", d5_sel_err); end
        d5_err_clr = 1'b1;
        tick();
        d5_err_clr = 1'b0;
        total++;
        if (d5_sel_err !== 1'b0) begin bad++; $display("[TB] FAIL oor_clear: got %b want 0", d5_sel_err); end
        d5_in_valid = 1'b1;
        d5_sel = 3'd4;
        tick();
        total++;
        if (d5_out_data !== 64'hA5A5_0000_0000_0004 || d5_sel_err !== 1'b0) begin
            bad++; $display("[TB] FAIL oor_last_legal: got %h err=%b want a5a5000000000004 err=0", d5_out_data, d5_sel_err);
        end
        d5_sel = 3'd5;
        tick();
        total++;
        if (d5_out_data !== 64'hDEAD_BEEF || d5_sel_err !== 1'b1) begin
            bad++; $display("[TB] FAIL oor_boundary: got %h err=%b want deadbeef err=1", d5_out_data, d5_sel_err);
        end
        d5_in_valid = 1'b0;
        d5_err_clr = 1'b1;
        tick();
        d5_in_valid = 1'b1;
        d5_sel = 3'd7;
        tick();
        d5_in_valid = 1'b0;
        d5_err_clr = 1'b0;
        total++;
        if (d5_sel_err !== 1'b1 || d5_out_sel !== 3'd7) begin
            bad++; $display("[TB] FAIL oor_set_wins: got err=%b sel=%0d want err=1 sel=7", d5_sel_err, d5_out_sel);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        load_basic8();
        d8_out_ready = 1'b0;
        d8_in_valid = 1'b1;
        d8_sel = 3'd5;
        step8();
        d8_sel = 3'd6;
        step8();
        d8_in_valid = 1'b0;
        total++;
        if (d8_in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rm_full: got %b want 0", d8_in_ready); end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (d8_out_valid !== 1'b0 || d8_out_data !== 64'h0 || d8_in_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL rm_async: got v=%b d=%h r=%b want v=0 d=0 r=1", d8_out_valid, d8_out_data, d8_in_ready);
        end
        total++;
        if (d5_sel_err !== 1'b0) begin bad++; $display("[TB] FAIL rm_sel_err: got %b want 0", d5_sel_err); end
        q8d.delete();
        q8s.delete();
        last8 = '0;
        @(posedge clk);
        #4;
        reset = 1'b0;
        tick();
        d8_out_ready = 1'b1;
        d8_in_valid = 1'b1;
        d8_sel = 3'd3;
        step8();
        total++;
        if (d8_out_valid !== 1'b1 || d8_out_data !== basic_word(3)) begin
            bad++; $display("[TB] FAIL rm_first_accept: got v=%b d=%h want v=1 d=%h", d8_out_valid, d8_out_data, basic_word(3));
        end
        d8_in_valid = 1'b0;
        step8();
    endtask

    task automatic test_stress();
        logic [31:0] q3d[$];
        logic [1:0]  q3s[$];
        logic        err_m;
        logic        acc;
        logic        pp;
        logic        exp_v;
        logic [31:0] exp_w;
        logic [1:0]  dummy;
        err_m = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            exp_v = (q3d.size() > 0);
            total++;
            if (d3_out_valid !== exp_v) begin bad++; $display("[TB] FAIL st_valid@%0d: got %b want %b", cyc, d3_out_valid, exp_v); end
            if (exp_v) begin
                total++;
                if (d3_out_data !== q3d[0] || d3_out_sel !== q3s[0]) begin
                    bad++; $display("[TB] FAIL st_data@%0d: got %h/%0d want %h/%0d", cyc, d3_out_data, d3_out_sel, q3d[0], q3s[0]);
                end
            end
            total++;
            if (d3_in_ready !== (q3d.size() < 2)) begin bad++; $display("[TB] FAIL st_ready@%0d: got %b want %b", cyc, d3_in_ready, q3d.size() < 2); end
            total++;
            if (d3_sel_err !== err_m) begin bad++; $display("[TB] FAIL st_err@%0d: got %b want %b", cyc, d3_sel_err, err_m); end

            d3_in_data   = {$urandom, $urandom, $urandom};
            d3_sel       = 2'($urandom_range(0, 3));
            d3_in_valid  = ($urandom_range(0, 3) != 0);
            d3_out_ready = ($urandom_range(0, 2) != 0);
            d3_err_clr   = ($urandom_range(0, 15) == 0);

            acc = d3_in_valid && (q3d.size() < 2);
            pp  = d3_out_ready && (q3d.size() > 0);
            if (pp) begin
                exp_w = q3d.pop_front();
                dummy = q3s.pop_front();
            end
            if (acc) begin
                exp_w = (d3_sel < 2'd3) ? d3_in_data[int'(d3_sel)*32 +: 32] : 32'h0;
                q3d.push_back(exp_w);
                q3s.push_back(d3_sel);
            end
            if (acc && d3_sel == 2'd3) err_m = 1'b1;
            else if (d3_err_clr) err_m = 1'b0;
            tick();
        end
        d3_in_valid = 1'b0;
        d3_err_clr = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        #2;
        reset = 1'b0;
        tick();
        test_reset();
        test_basic_select();
        test_idle();
        test_backpressure();
        test_no_accept();
        test_out_of_range();
        test_reset_mid();
        test_stress();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
